// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter feeding a single register-file write port.
// Conflict policy: define WB_ARB_RR_EN for round-robin, otherwise req0 has fixed priority.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      req0_valid,
  input  logic [REG_ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0]     req0_data,
  input  logic                      req1_valid,
  input  logic [REG_ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0]     req1_data,
  output logic                      req0_ready,
  output logic                      req1_ready,
  output logic                      reg_write_en,
  output logic [REG_ADDR_WIDTH-1:0] write_reg_addr,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic [15:0]               conflict_cnt
);

  localparam int unsigned          CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  logic                      w_open;
  logic                      w_conflict;
  logic                      w_pref1;
  logic                      w_grant0;
  logic                      w_grant1;
  logic                      w_accept;
  logic [REG_ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0]     w_data;

  logic                      r_write_en;
  logic [REG_ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0]      r_cnt;

`ifdef WB_ARB_RR_EN
  // One-bit pointer: on conflict the requester that did not win last gets the port.
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant1;
    end
  end

  assign w_pref1 = ~r_last_grant;
`else
  assign w_pref1 = 1'b0;
`endif

  // Grant selection and mux of the winning payload.
  always_comb begin
    w_open     = ~stall & ~reset;
    w_conflict = req0_valid & req1_valid & ~stall;
    w_grant1   = w_open & req1_valid & (~req0_valid | w_pref1);
    w_grant0   = w_open & req0_valid & ~w_grant1;
    w_accept   = w_grant0 | w_grant1;
    w_addr     = w_grant1 ? req1_addr : req0_addr;
    w_data     = w_grant1 ? req1_data : req0_data;
  end

  // Register 0 is hard-wired, so an accepted write to it never raises the enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write_en <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
    end else begin
      r_write_en <= w_accept && (w_addr != '0);
      if (w_accept) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
      if (w_conflict && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign req0_ready     = w_grant0;
  assign req1_ready     = w_grant1;
  assign reg_write_en   = r_write_en;
  assign write_reg_addr = r_addr;
  assign write_data     = r_data;
  assign conflict_cnt   = r_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios then randomized traffic
// against a transaction-level reference model.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          stall = 1'b0;
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic          req0_ready;
  logic          req1_ready;
  logic          reg_write_en;
  logic [AW-1:0] write_reg_addr;
  logic [DW-1:0] write_data;
  logic [15:0]   conflict_cnt;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .reg_write_en(reg_write_en), .write_reg_addr(write_reg_addr),
    .write_data(write_data), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int obs_g;

  // Reference model state: what the register-file port should show, and who won last.
  bit          m_en;
  bit [AW-1:0] m_addr;
  bit [DW-1:0] m_data;
  int unsigned m_cnt;
  int          m_last = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    if (reset || stall) return -1;
    if (req0_valid && req1_valid) begin
`ifdef WB_ARB_RR_EN
      return 1 - m_last;
`else
      return 0;
`endif
    end
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Called just after a falling edge with inputs already driven; returns after the next falling edge.
  task automatic step();
    int g;
    #1;
    g = model_grant();
    chk("ready0", 32'(req0_ready), 32'(g == 0));
    chk("ready1", 32'(req1_ready), 32'(g == 1));
    obs_g = req1_ready ? 1 : (req0_ready ? 0 : -1);
    @(posedge clk);
    if (reset) begin
      m_en = 0; m_addr = '0; m_data = '0; m_cnt = 0; m_last = 1;
    end else begin
      if (req0_valid && req1_valid && !stall && m_cnt < 32'hFFFF) m_cnt++;
      if (g >= 0) begin
        m_addr = (g == 1) ? req1_addr : req0_addr;
        m_data = (g == 1) ? req1_data : req0_data;
        m_en   = (m_addr != 0);
        m_last = g;
      end else begin
        m_en = 0;
      end
    end
    @(negedge clk);
    chk("wr_en",   32'(reg_write_en),   32'(m_en));
    chk("wr_addr", 32'(write_reg_addr), 32'(m_addr));
    chk("wr_data", write_data,          m_data);
    chk("cnt",     32'(conflict_cnt),   m_cnt);
  endtask

  task automatic drive(input logic rst, input logic st,
                       input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    reset = rst; stall = st;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
  endtask

  int exp_seq[4];

  initial begin
    @(negedge clk);
    // Reset state
    drive(1, 0, 1, 5'd3, 32'h1111_1111, 1, 5'd4, 32'h2222_2222);
    step();
    step();
    chk("rst_en", 32'(reg_write_en), 32'd0);
    chk("rst_cnt", 32'(conflict_cnt), 32'd0);

    // Single requester, latency one cycle to enable
    drive(0, 0, 1, 5'd5, 32'hAAAA_5555, 0, 5'd0, 32'd0);
    step();
    chk("single_grant", 32'(obs_g), 32'd0);
    chk("single_en", 32'(reg_write_en), 32'd1);
    chk("single_addr", 32'(write_reg_addr), 32'd5);
    chk("single_data", write_data, 32'hAAAA_5555);

    // Idle cycle: enable drops, payload holds
    drive(0, 0, 0, 5'd9, 32'h0, 0, 5'd9, 32'h0);
    step();
    chk("idle_hold", write_data, 32'hAAAA_5555);

    // Four conflicting cycles from a fresh reset
    drive(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    step();
`ifdef WB_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 5'd1, 32'h100 + 32'(i), 1, 5'd2, 32'h200 + 32'(i));
      step();
      chk("conflict_seq", 32'(obs_g), 32'(exp_seq[i]));
    end
    chk("conflict_cnt4", 32'(conflict_cnt), 32'd4);

    // Write to register 0 is accepted but never enabled
    drive(0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF);
    step();
    chk("r0_grant", 32'(obs_g), 32'd1);
    chk("r0_en", 32'(reg_write_en), 32'd0);

    // Stall blocks everything and does not count conflicts
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88);
      step();
      chk("stall_grant", 32'(obs_g), 32'hFFFF_FFFF);
      chk("stall_en", 32'(reg_write_en), 32'd0);
    end
    chk("stall_cnt", 32'(conflict_cnt), 32'd4);

    // Reset mid-stream, then req0 wins the first conflict
    drive(0, 0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    step();
    step();
    drive(1, 0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    step();
    chk("mid_rst_grant", 32'(obs_g), 32'hFFFF_FFFF);
    chk("mid_rst_en", 32'(reg_write_en), 32'd0);
    chk("mid_rst_addr", 32'(write_reg_addr), 32'd0);
    step();
    drive(0, 0, 1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0);
    step();
    chk("post_rst_grant", 32'(obs_g), 32'd0);

    // Saturation from a preloaded near-max count
    force dut.r_cnt = 16'hFFFE;
    #1;
    release dut.r_cnt;
    m_cnt = 32'hFFFE;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 5'd12, 32'hC0 + 32'(i), 1, 5'd13, 32'hD0 + 32'(i));
      step();
    end
    chk("sat_cnt", 32'(conflict_cnt), 32'hFFFF);

    // Randomized traffic; a requester that is not granted holds its request
    drive(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    step();
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      stall = ($urandom_range(0, 7) == 0);
      if (!req0_valid || obs_g == 0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_addr  = AW'($urandom);
        req0_data  = $urandom;
      end
      if (!req1_valid || obs_g == 1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_addr  = AW'($urandom);
        req1_data  = $urandom;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data width of each register file write.
REQ-002 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1  when 1, no grants are issued this cycle.
REQ-006 SHALL have ports req0_valid/req1_valid  input  1  requester n presents a write.
REQ-007 SHALL have ports req0_addr/req1_addr  input  REG_ADDR_WIDTH  destination register.
REQ-008 SHALL have ports req0_data/req1_data  input  DATA_WIDTH  write value.
REQ-009 SHALL have ports req0_ready/req1_ready  output  1  combinational grant; the transfer occurs when valid and ready are both 1 at a rising edge.
REQ-010 SHALL have port reg_write_en  output  1  registered write enable to the register file.
REQ-011 SHALL have port write_reg_addr  output  REG_ADDR_WIDTH  registered write address.
REQ-012 SHALL have port write_data  output  DATA_WIDTH  registered write data.
REQ-013 SHALL have port conflict_cnt  output  16  count of cycles with both valids high and stall low; saturates.

Function
REQ-014 SHALL assert at most one readyN per cycle; readyN is never 1 unless reqN_valid is 1.
REQ-015 SHALL deassert both readys while stall=1 or reset=1.
REQ-016 SHALL grant the only valid requester when exactly one valid is high and stall=0.
REQ-017 SHALL, when both are valid and stall=0, choose the winner per REQ-030/REQ-031; the loser sees ready=0 and holds its request unchanged.
REQ-018 SHALL register the granted addr/data into write_reg_addr/write_data at the accepting edge; reg_write_en is 1 in the following cycle (latency 1 cycle from acceptance to enable).
REQ-019 SHALL drive reg_write_en=0 in any cycle following an edge with no accepted transfer; write_reg_addr/write_data then hold their previous values.
REQ-020 SHALL accept a request with addr 0 (ready=1, counts as a grant for round-robin) but drive reg_write_en=0 for it, since register 0 is never written.
REQ-021 SHALL sustain one accepted write per cycle with no bubbles when requests are continuously valid and stall=0.
REQ-022 SHALL increment conflict_cnt by 1 at each edge where both valids are 1 and stall=0, holding at 16'hFFFF.
REQ-023 SHALL treat the round-robin pointer as one bit: last_grant, updated only on an accepted transfer to the index granted.

Reset
REQ-024 SHALL, at a rising edge with reset=1, clear reg_write_en, write_reg_addr, write_data and conflict_cnt to 0.
REQ-025 SHALL set last_grant to 1 on reset so req0 wins the first conflict.
REQ-026 SHALL discard any request presented in a reset cycle (not accepted, not buffered).
REQ-027 SHALL, when reset asserts in the cycle after an acceptance, drive reg_write_en=0 from the next cycle on; the in-flight enable already presented in that cycle is not suppressed combinationally.
REQ-028 SHALL resume normal arbitration in the first cycle after reset deasserts.

Configuration
REQ-029 SHALL use macro WB_ARB_RR_EN to select the conflict policy.
REQ-030 SHALL, with WB_ARB_RR_EN defined, grant the requester not equal to last_grant on conflict (round-robin).
REQ-031 SHALL, without WB_ARB_RR_EN, always grant req0 on conflict (fixed priority); last_grant is then not implemented.

Verification
REQ-032 SHALL check: reset, then req0_valid=1 addr=5 data=0xAAAA5555 -> req0_ready=1; next cycle reg_write_en=1, write_reg_addr=5, write_data=0xAAAA5555.
REQ-033 SHALL check: both valid for 4 cycles (addr 1 / addr 2), RR build -> grants 0,1,0,1, conflict_cnt=4; fixed build -> grants 0,0,0,0.
REQ-034 SHALL check: req1_valid=1 addr=0 data=0xFFFFFFFF -> req1_ready=1; next cycle reg_write_en=0.
REQ-035 SHALL check: stall=1 with both valid for 3 cycles -> both ready=0, reg_write_en=0, conflict_cnt unchanged.
REQ-036 SHALL check: reset asserted mid-stream with both valid -> readys 0 during reset, outputs cleared, req0 wins the first conflict after release.
REQ-037 SHALL check: force conflict_cnt to 16'hFFFE, then 3 conflict cycles -> conflict_cnt=16'hFFFF.
